// File: rtl/morra_match_controller_if.sv
// Player move handshakes for the Morra match controller: one valid/ready/move
// channel per player; the player side drives valid/move, the controller drives ready.
interface morra_match_controller_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready
  );

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready
  );
endinterface

// File: rtl/morra_match_controller.sv
// Match sequencer in front of the Morracinese core: configures the core, collects both moves,
// applies them for one cycle, samples the round result. Optional MORRA_SCOREBOARD_EN adds win/draw counters.
module morra_match_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MIN_MANCHE     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cfg_extra,
  // Handshake: a move transfers in a cycle where pN_valid and pN_ready are both high;
  // ready is high only in COLLECT while that player's slot is empty, valid may be raised at any time.
  morra_match_controller_if.slave moves,
  output logic       core_reset,
  output logic [1:0] core_primo,
  output logic [1:0] core_secondo,
  input  logic [1:0] core_manche,
  input  logic [1:0] core_partita,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [4:0] round_idx,
  output logic       bad_move,
  output logic       timeout,
`ifdef MORRA_SCOREBOARD_EN
  output logic [4:0] p1_wins,
  output logic [4:0] p2_wins,
  output logic [4:0] draws,
`endif
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_COLLECT = 3'd2,
    S_APPLY   = 3'd3,
    S_RESULT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int              TW    = 10;
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  extra_q;
  logic        s1_full, s2_full;
  logic [1:0]  s1_move, s2_move;
  logic [TW-1:0] timer;
  logic        timeout_q;

  logic        p1_xfer, p2_xfer, p1_take, p2_take;
  logic        both_full_next, one_full;
  logic        accept_start, go_timeout, match_end;
  logic [4:0]  new_idx;
  logic [5:0]  limit;

  assign p1_xfer        = (state == S_COLLECT) && moves.p1_valid && !s1_full;
  assign p2_xfer        = (state == S_COLLECT) && moves.p2_valid && !s2_full;
  assign p1_take        = p1_xfer && (moves.p1_move != 2'b00);
  assign p2_take        = p2_xfer && (moves.p2_move != 2'b00);
  assign both_full_next = (s1_full || p1_take) && (s2_full || p2_take);
  assign one_full       = s1_full ^ s2_full;
  assign new_idx        = (round_idx == 5'd31) ? 5'd31 : round_idx + 5'd1;
  assign limit          = 6'(MIN_MANCHE) + {2'b00, extra_q};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    core_reset     = 1'b0;
    core_primo     = 2'b00;
    core_secondo   = 2'b00;
    moves.p1_ready = 1'b0;
    moves.p2_ready = 1'b0;
    bad_move       = 1'b0;
    accept_start   = 1'b0;
    go_timeout     = 1'b0;
    match_end      = 1'b0;
    case (state)
      S_IDLE: begin
        core_reset = 1'b1;
        if (start) begin
          accept_start = 1'b1;
          state_next   = S_CONFIG;
        end
      end
      S_CONFIG: begin
        core_reset   = 1'b1;
        core_primo   = extra_q[3:2];
        core_secondo = extra_q[1:0];
        state_next   = S_COLLECT;
      end
      S_COLLECT: begin
        moves.p1_ready = !s1_full;
        moves.p2_ready = !s2_full;
        bad_move       = (p1_xfer && !p1_take) || (p2_xfer && !p2_take);
        // A completing second move in the expiry cycle takes priority over the forfeit.
        if (both_full_next) begin
          state_next = S_APPLY;
        end else if (one_full && timer == TLAST) begin
          go_timeout = 1'b1;
          state_next = S_DONE;
        end
      end
      S_APPLY: begin
        core_primo   = s1_move;
        core_secondo = s2_move;
        state_next   = S_RESULT;
      end
      S_RESULT: begin
        state_next = S_COLLECT;
        if (core_manche != 2'b00 &&
            (core_partita != 2'b00 || {1'b0, new_idx} == limit)) begin
          match_end  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      extra_q   <= 4'd0;
      s1_full   <= 1'b0;
      s2_full   <= 1'b0;
      s1_move   <= 2'b00;
      s2_move   <= 2'b00;
      timer     <= '0;
      timeout_q <= 1'b0;
      round_idx <= 5'd0;
      winner    <= 2'b00;
    end else begin
      timeout_q <= go_timeout;
      if (accept_start) begin
        extra_q   <= cfg_extra;
        round_idx <= 5'd0;
        winner    <= 2'b00;
      end
      // Slots and timer are emptied both between matches and after every applied round.
      if (state == S_IDLE || state == S_APPLY) begin
        s1_full <= 1'b0;
        s2_full <= 1'b0;
        timer   <= '0;
      end
      if (state == S_COLLECT) begin
        if (p1_take) begin
          s1_full <= 1'b1;
          s1_move <= moves.p1_move;
        end
        if (p2_take) begin
          s2_full <= 1'b1;
          s2_move <= moves.p2_move;
        end
        if (one_full) timer <= timer + 1'b1;
        if (go_timeout) winner <= s1_full ? 2'b01 : 2'b10;
      end
      if (state == S_RESULT && core_manche != 2'b00) begin
        round_idx <= new_idx;
        if (match_end) winner <= (core_partita != 2'b00) ? core_partita : 2'b11;
      end
    end
  end

`ifdef MORRA_SCOREBOARD_EN
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      p1_wins <= 5'd0;
      p2_wins <= 5'd0;
      draws   <= 5'd0;
    end else if (state == S_RESULT) begin
      case (core_manche)
        2'b01:   p1_wins <= sat_inc(p1_wins);
        2'b10:   p2_wins <= sat_inc(p2_wins);
        2'b11:   draws   <= sat_inc(draws);
        default: ;
      endcase
    end
  end
`endif

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign timeout   = timeout_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_morra_match_controller.sv
// Directed plus randomized bench for morra_match_controller; the bench plays the game core
// and predicts outcomes from match rules (round count, limit, forfeit, core verdict).
module tb_morra_match_controller;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cfg_extra;
  logic [1:0] core_manche, core_partita;
  logic       core_reset, busy, done, bad_move, timeout;
  logic [1:0] core_primo, core_secondo, winner;
  logic [4:0] round_idx;
  logic [2:0] state_dbg;
`ifdef MORRA_SCOREBOARD_EN
  logic [4:0] p1_wins, p2_wins, draws;
  int exp_p1w, exp_p2w, exp_dr;
`endif

  morra_match_controller_if mif ();

  morra_match_controller #(.TIMEOUT_CYCLES(TO), .MIN_MANCHE(4)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_extra    (cfg_extra),
    .moves        (mif),
    .core_reset   (core_reset),
    .core_primo   (core_primo),
    .core_secondo (core_secondo),
    .core_manche  (core_manche),
    .core_partita (core_partita),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .round_idx    (round_idx),
    .bad_move     (bad_move),
    .timeout      (timeout),
`ifdef MORRA_SCOREBOARD_EN
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .draws        (draws),
`endif
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Match-level reference: valid rounds so far, round cap, predicted winner.
  int         exp_idx;
  int         exp_limit;
  logic [1:0] exp_winner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_match(input logic [3:0] extra);
    start = 1'b1;
    cfg_extra = extra;
    tick();
    start = 1'b0;
    cfg_extra = 4'($urandom);
    #1;
    chk("cfg_core_reset", core_reset, 1);
    chk("cfg_primo", core_primo, extra[3:2]);
    chk("cfg_secondo", core_secondo, extra[1:0]);
    chk("cfg_busy", busy, 1);
    chk("cfg_winner_clr", winner, 0);
    chk("cfg_round_clr", round_idx, 0);
    chk("cfg_ready", {mif.p1_ready, mif.p2_ready}, 0);
    tick();
    chk("collect_ready", {mif.p1_ready, mif.p2_ready}, 2'b11);
    chk("collect_core_reset", core_reset, 0);
    exp_idx = 0;
    exp_limit = 4 + int'(extra);
    exp_winner = 2'b00;
`ifdef MORRA_SCOREBOARD_EN
    exp_p1w = 0; exp_p2w = 0; exp_dr = 0;
`endif
  endtask

  task automatic drive_p(input bit second, input bit v, input logic [1:0] m);
    if (second) begin mif.p2_valid = v; mif.p2_move = m; end
    else        begin mif.p1_valid = v; mif.p1_move = m; end
  endtask

  // gap = cycles from the first transfer to the second; 0 means same cycle. Ends in APPLY.
  task automatic send_moves(input logic [1:0] m1, input logic [1:0] m2, input int gap, input bit p2_first);
    if (gap == 0) begin
      drive_p(0, 1, m1);
      drive_p(1, 1, m2);
      #1;
      chk("same_cycle_ready", {mif.p1_ready, mif.p2_ready}, 2'b11);
      tick();
      drive_p(0, 0, 2'b00);
      drive_p(1, 0, 2'b00);
    end else begin
      drive_p(p2_first, 1, p2_first ? m2 : m1);
      tick();
      drive_p(p2_first, 0, 2'b00);
      #1;
      chk("first_slot_ready", p2_first ? mif.p2_ready : mif.p1_ready, 0);
      chk("other_slot_ready", p2_first ? mif.p1_ready : mif.p2_ready, 1);
      repeat (gap - 1) tick();
      chk("no_early_timeout", {timeout, done}, 0);
      drive_p(!p2_first, 1, p2_first ? m1 : m2);
      tick();
      drive_p(!p2_first, 0, 2'b00);
    end
    #1;
    chk("apply_primo", core_primo, m1);
    chk("apply_secondo", core_secondo, m2);
    chk("apply_ready", {mif.p1_ready, mif.p2_ready}, 0);
  endtask

  task automatic finish_round(input logic [1:0] manche, input logic [1:0] partita, output bit ended);
    core_manche = manche;
    core_partita = partita;
    tick();
    chk("result_moves", {core_primo, core_secondo}, 0);
    chk("result_round_hold", round_idx, exp_idx);
    tick();
    core_manche = 2'b00;
    core_partita = 2'b00;
    ended = 0;
    if (manche != 2'b00) begin
      exp_idx = (exp_idx < 31) ? exp_idx + 1 : 31;
`ifdef MORRA_SCOREBOARD_EN
      if (manche == 2'b01) exp_p1w++;
      if (manche == 2'b10) exp_p2w++;
      if (manche == 2'b11) exp_dr++;
`endif
      if (partita != 2'b00) begin ended = 1; exp_winner = partita; end
      else if (exp_idx == exp_limit) begin ended = 1; exp_winner = 2'b11; end
    end
    #1;
    chk("round_idx", round_idx, exp_idx);
    chk("done_pulse", done, ended);
`ifdef MORRA_SCOREBOARD_EN
    chk("sb_counts", {p1_wins, p2_wins, draws}, {5'(exp_p1w), 5'(exp_p2w), 5'(exp_dr)});
`endif
    if (ended) begin
      chk("done_winner", winner, exp_winner);
      chk("done_busy", busy, 1);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("winner_held", winner, exp_winner);
    end else begin
      chk("next_round_ready", {mif.p1_ready, mif.p2_ready}, 2'b11);
      chk("winner_pending", winner, 0);
    end
  endtask

  task automatic forfeit_round(input bit p2_first);
    drive_p(p2_first, 1, 2'($urandom_range(1, 3)));
    tick();
    drive_p(p2_first, 0, 2'b00);
    repeat (TO - 1) tick();
    chk("pre_expiry", {timeout, done}, 0);
    tick();
    exp_winner = p2_first ? 2'b10 : 2'b01;
    chk("to_pulse", timeout, 1);
    chk("to_done", done, 1);
    chk("to_winner", winner, exp_winner);
    chk("to_round_idx", round_idx, exp_idx);
    tick();
    chk("to_busy_after", busy, 0);
    chk("to_pulse_end", timeout, 0);
    chk("to_winner_held", winner, exp_winner);
  endtask

  initial begin
    bit ended;
    logic [1:0] m1, m2, mv, pv;
    reset = 1'b1;
    start = 1'b0;
    cfg_extra = 4'd0;
    core_manche = 2'b00;
    core_partita = 2'b00;
    mif.p1_valid = 1'b0; mif.p1_move = 2'b00;
    mif.p2_valid = 1'b0; mif.p2_move = 2'b00;
    tick();
    tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_moves", {core_primo, core_secondo}, 0);
    chk("rst_flags", {busy, done, bad_move, timeout}, 0);
    chk("rst_winner", winner, 0);
    chk("rst_round", round_idx, 0);
    chk("rst_ready", {mif.p1_ready, mif.p2_ready}, 0);
    reset = 1'b0;
    tick();

    // Config cycle, then one same-cycle round won by p1.
    start_match(4'b0001);
    send_moves(2'b01, 2'b11, 0, 0);
    finish_round(2'b01, 2'b00, ended);

    // Bad move is dropped; a later good move fills the slot.
    mif.p1_valid = 1'b1; mif.p1_move = 2'b00;
    #1;
    chk("bad_move_pulse", bad_move, 1);
    tick();
    mif.p1_move = 2'b10;
    #1;
    chk("bad_move_end", bad_move, 0);
    chk("bad_slot_empty", mif.p1_ready, 1);
    tick();
    mif.p1_valid = 1'b0;
    #1;
    chk("good_move_latched", mif.p1_ready, 0);
    // Second move lands exactly in the expiry cycle and must win over the forfeit.
    repeat (TO - 1) tick();
    mif.p2_valid = 1'b1; mif.p2_move = 2'b01;
    tick();
    mif.p2_valid = 1'b0;
    #1;
    chk("expiry_apply_primo", core_primo, 2'b10);
    chk("expiry_apply_secondo", core_secondo, 2'b01);
    finish_round(2'b10, 2'b00, ended);

    // Player 2 silent: p1 wins by forfeit.
    forfeit_round(0);

    // Four p1 rounds; core declares p1 match winner in the fourth.
    start_match(4'b0000);
    send_moves(2'b01, 2'b11, 0, 0); finish_round(2'b01, 2'b00, ended);
    send_moves(2'b10, 2'b01, 2, 0); finish_round(2'b01, 2'b00, ended);
    send_moves(2'b11, 2'b10, 3, 1); finish_round(2'b01, 2'b00, ended);
    send_moves(2'b01, 2'b11, 0, 0); finish_round(2'b01, 2'b01, ended);
    chk("p1_match_ended", ended, 1);

    // Reset during APPLY abandons the match silently.
    start_match(4'b0010);
    send_moves(2'b01, 2'b10, 0, 0);
    reset = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_round", round_idx, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    tick();
    chk("midrst_no_done", {done, busy}, 0);

    // start while busy is ignored: the cap stays at 4 draws.
    start_match(4'b0000);
    start = 1'b1; cfg_extra = 4'hF;
    tick();
    start = 1'b0;
    #1;
    chk("busy_start_ignored", core_reset, 0);
    chk("busy_start_collect", mif.p1_ready, 1);
    for (int r = 0; r < 4; r++) begin
      send_moves(2'(r % 3 + 1), 2'(r % 3 + 1), 1, r[0]);
      finish_round(2'b11, 2'b00, ended);
    end
    chk("draw_cap_ended", ended, 1);

    // Randomized matches against the match-level model.
    for (int g = 0; g < 30; g++) begin
      start_match(4'($urandom_range(0, 3)));
      ended = 0;
      for (int r = 0; r < 60 && !ended; r++) begin
        if ($urandom_range(0, 14) == 0) begin
          forfeit_round(1'($urandom_range(0, 1)));
          ended = 1;
        end else begin
          m1 = 2'($urandom_range(1, 3));
          m2 = 2'($urandom_range(1, 3));
          send_moves(m1, m2, $urandom_range(0, TO), 1'($urandom_range(0, 1)));
          mv = 2'($urandom_range(0, 3));
          pv = (mv != 2'b00 && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          finish_round(mv, pv, ended);
        end
      end
      chk("rand_match_ended", ended, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morra_match_controller.md
Name: morra_match_controller

Overview:
Match-level sequencer in front of the Morracinese game core. It collects one move per player through independent valid/ready handshakes. It configures the core's manche limit at match start, then presents each move pair to the core for exactly one clock. It samples the round result, enforces a per-round move timeout and reports the match winner.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed for the second player's move after the first is latched (1..1023)
MIN_MANCHE, 4, base manche count; hard round cap = MIN_MANCHE + cfg_extra

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  start-match request, sampled only in IDLE
cfg_extra  in  4  extra manches for this match, latched on accepted start
p1_valid  in  1  player 1 move valid
p1_move  in  2  01 sasso, 10 carta, 11 forbice
p1_ready  out  1  player 1 slot empty and accepting
p2_valid, p2_move, p2_ready  as player 1
core_reset  out  1  reset to game core
core_primo  out  2  move/config to core, player 1 field
core_secondo  out  2  move/config to core, player 2 field
core_manche  in  2  core round result (00 invalid, 01 p1, 10 p2, 11 draw)
core_partita  in  2  core match result (00 ongoing)
busy  out  1  high from CONFIG through DONE
done  out  1  one-cycle pulse on entering DONE
winner  out  2  01 p1, 10 p2, 11 draw; held until next accepted start
round_idx  out  5  count of valid (non-00) rounds this match
bad_move  out  1  one-cycle pulse when a 00 move is handshaken
timeout  out  1  one-cycle pulse on forfeit

Behaviour:
- Reset: state IDLE; core_reset=1; core_primo/secondo=00; ready=0; busy=done=bad_move=timeout=0; winner=00; round_idx=0; slots empty; timer=0.
- States: IDLE, CONFIG, COLLECT, APPLY, RESULT, DONE.
- IDLE: core_reset=1, moves 00. start=1 → CONFIG; latch cfg_extra; clear round_idx and winner.
- CONFIG (1 cycle): core_reset=1, core_primo=cfg_extra[3:2], core_secondo=cfg_extra[1:0] → COLLECT.
- COLLECT: core_reset=0, moves 00. pN_ready = slot N empty.
  - A transfer is pN_valid & pN_ready.
  - Move 00: discarded, slot stays empty, bad_move pulse.
  - Both slots full (same-cycle transfers allowed) → APPLY.
- Timer: counts only while exactly one slot is full.
  - Reaching TIMEOUT_CYCLES → DONE with winner = the full slot's player, plus a timeout pulse.
  - A simultaneous second transfer in the expiry cycle wins over the timeout; go to APPLY.
- APPLY (1 cycle): drive latched moves onto core_primo/secondo; clear slots and timer → RESULT.
- RESULT: moves 00; sample core_manche.
  - 00 (core rejected, e.g. repeated move): round_idx unchanged → COLLECT.
  - Non-00: round_idx+1, then test the match end:
    - core_partita≠00 → DONE, winner=core_partita.
    - Else new round_idx == MIN_MANCHE+cfg_extra → DONE, winner=11.
    - Else → COLLECT.
- DONE (1 cycle): done=1 → IDLE.
- Latency:
  - Start to first ready = 2 cycles.
  - Second move handshake to RESULT sample = 2 cycles.
- start while busy: ignored. Inputs while in IDLE/CONFIG/APPLY/RESULT: ready=0, nothing accepted.
- Reset mid-match: immediate return to reset values; the partial match is lost, and winner is not reported.
- round_idx saturates at 31.

Optional Feature:
MORRA_SCOREBOARD_EN
- Defined: adds outputs p1_wins, p2_wins, draws (5 bits each, saturating).
  - Cleared on accepted start.
  - Incremented in RESULT for core_manche 01/10/11 respectively.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. reset, start, cfg_extra=0001 → CONFIG cycle shows core_reset=1, core_primo=00, core_secondo=01; 2 cycles after start, p1_ready=p2_ready=1, busy=1.
2. p1 01, p2 11 handshaken in the same cycle → APPLY drives 01/11 for one cycle; RESULT sees manche=01, round_idx=1, back in COLLECT.
3. p1 sends 00 → bad_move pulse, p1_ready stays 1; then p1 sends 10 → p1_ready=0.
4. p1 move latched, p2 silent, TIMEOUT_CYCLES=8 → after 8 cycles, timeout and done pulse, winner=01, busy=0 next cycle.
5. p1 wins 4 distinct valid rounds with cfg_extra=0 on the real core → core_partita=01 in the 4th RESULT, done, winner=01, round_idx=4.
6. Reset asserted during APPLY → next cycle IDLE, core_reset=1, round_idx=0, no done pulse; start while busy produces no restart.
